// File: rtl/rf_wb_arbiter_pkg.sv
// Shared constants for the register-file writeback arbiter.
// Register zero is hard-wired, so it never owns a pending write.
package rf_wb_arbiter_pkg;
    localparam int RF_AW    = 5;
    localparam int RF_XLEN  = 32;
    localparam int RF_NREGS = 32;
    localparam int RF_ZERO  = 0;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the search starts one past the last winner.
// Produces a one-hot grant plus its encoded index.
module rr_arbiter #(
    parameter int NREQ = 3,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   grant_idx,
    output logic            grant_valid
);
    logic [IW-1:0] ptr;
    logic [IW:0]   sum;
    logic [IW-1:0] idx;

    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        sum         = '0;
        idx         = '0;
        for (int k = 1; k <= NREQ; k++) begin
            sum = {1'b0, ptr} + (IW+1)'(k);
            if (sum >= (IW+1)'(NREQ)) begin
                sum = sum - (IW+1)'(NREQ);
            end
            idx = sum[IW-1:0];
            if (!grant_valid && req[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = idx;
                grant[idx]  = 1'b1;
            end
        end
    end

    // Reset to the last index so requester 0 wins the first contest.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= IW'(NREQ - 1);
        end else if (grant_valid) begin
            ptr <= grant_idx;
        end
    end
endmodule

// File: rtl/rf_wb_arbiter.sv
// Owns the register-file write port: round-robin writeback arbitration,
// registered write stage, and a per-register pending-write scoreboard.
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int XLEN = RF_XLEN,
    parameter int AW   = RF_AW,
    parameter int CW   = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*XLEN-1:0] req_data,
    input  logic                 issue_valid,
    input  logic [AW-1:0]        issue_rd,
    output logic                 issue_stall,
    output logic [RF_NREGS-1:0]  busy,
    output logic                 rd_we,
    output logic [AW-1:0]        rd_addr,
    output logic [XLEN-1:0]      rd_wdata,
    output logic                 err_underflow
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [IW-1:0]       grant_idx;
    logic                grant_valid;
    logic [AW-1:0]       sel_addr;
    logic [XLEN-1:0]     sel_data;
    logic                wr_fire;
    logic [CW-1:0]       cnt [RF_NREGS];
    logic [RF_NREGS-1:0] inc;
    logic [RF_NREGS-1:0] dec;

    rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req_valid),
        .grant       (req_ready),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_idx == IW'(i)) begin
                sel_addr = req_addr[i*AW +: AW];
                sel_data = req_data[i*XLEN +: XLEN];
            end
        end
    end

    // A grant to register zero is consumed but never reaches the regfile.
    assign wr_fire = grant_valid && (sel_addr != AW'(RF_ZERO));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_we    <= 1'b0;
            rd_addr  <= '0;
            rd_wdata <= '0;
        end else begin
            rd_we <= wr_fire;
            if (wr_fire) begin
                rd_addr  <= sel_addr;
                rd_wdata <= sel_data;
            end
        end
    end

    assign issue_stall = issue_valid && (issue_rd != AW'(RF_ZERO)) && (cnt[issue_rd] == '1);

    always_comb begin
        inc  = '0;
        dec  = '0;
        busy = '0;
        for (int r = 1; r < RF_NREGS; r++) begin
            inc[r]  = issue_valid && !issue_stall && (issue_rd == AW'(r));
            dec[r]  = rd_we && (rd_addr == AW'(r));
            busy[r] = (cnt[r] != '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < RF_NREGS; r++) begin
                cnt[r] <= '0;
            end
            err_underflow <= 1'b0;
        end else begin
            for (int r = 1; r < RF_NREGS; r++) begin
                if (inc[r] && !dec[r]) begin
                    cnt[r] <= cnt[r] + CW'(1);
                end else if (dec[r] && !inc[r]) begin
                    if (cnt[r] == '0) begin
                        err_underflow <= 1'b1;
                    end else begin
                        cnt[r] <= cnt[r] - CW'(1);
                    end
                end
            end
        end
    end
endmodule
